// File: rtl/disp_pkg.sv
// Shared constants for the display scan controller: frame layout, FSM states
// and the 7-segment glyph table (bit 0 = segment a).
package disp_pkg;

  localparam int FRAME_W  = 24;
  localparam int SEG_LSB  = 16;
  localparam int DIG_LSB  = 8;
  localparam int AUX_LSB  = 0;
  localparam int XFER_MIN = 52;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PULSE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Segment byte {dp,g,f,e,d,c,b,a} without dp, indexed by nibble value 0..F.
  localparam logic [7:0] SEG_GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble + decimal point to active-high segment byte {dp,g..a}.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  assign glyph = SEG_GLYPH[value];
  assign seg   = {dp, glyph[6:0]};

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan sequencer feeding a 24-bit shift-register writer.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero in the top digit.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int XFER_CYCLES = 56
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_tick,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_digits,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic [7:0]              upd_aux,
  input  logic                    blank,
  output logic [FRAME_W-1:0]      wr_data,
  output logic                    wr_valid,
  output logic                    busy,
  output logic [2:0]              digit_idx,
  output logic                    overrun
);

  localparam int CNT_W = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;

  if (XFER_CYCLES < XFER_MIN) begin : g_xfer_check
    $error("disp_scan_ctrl: XFER_CYCLES too small for the shift-register writer");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_digits_check
    $error("disp_scan_ctrl: NUM_DIGITS must be 1..8");
  end

  state_e                  state;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    pend_full;
  logic                    active_valid;
  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [7:0]              pend_aux, act_aux;

  logic                    use_pend;
  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [7:0]              src_aux;
  logic                    src_valid;
  logic [3:0]              cur_val;
  logic                    cur_dp;
  logic [7:0]              seg_raw, seg_eff;
  logic                    lz_blank;
  logic [FRAME_W-1:0]      frame;
  logic                    last_digit;

  assign upd_ready  = !pend_full;
  assign busy       = (state != ST_IDLE);
  assign wr_valid   = (state == ST_PULSE);
  assign last_digit = (digit_idx == 3'(NUM_DIGITS - 1));

  // A pending update is promoted at a digit-0 load so one scan never mixes contents.
  assign use_pend   = pend_full && (digit_idx == 3'd0);
  assign src_digits = use_pend ? pend_digits : act_digits;
  assign src_dp     = use_pend ? pend_dp     : act_dp;
  assign src_aux    = use_pend ? pend_aux    : act_aux;
  assign src_valid  = use_pend || active_valid;
  assign cur_val    = src_digits[{digit_idx, 2'b00} +: 4];
  assign cur_dp     = src_dp[digit_idx];

  seg7_decode u_dec (
    .value (cur_val),
    .dp    (cur_dp),
    .seg   (seg_raw)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign lz_blank = last_digit && (cur_val == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif
  assign seg_eff = lz_blank ? {cur_dp, 7'b0} : seg_raw;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    frame = '0;
    if (src_valid) begin
      frame[AUX_LSB +: 8] = src_aux;
      if (!blank) begin
        frame[SEG_LSB +: 8] = seg_eff;
        frame[DIG_LSB +: 8] = 8'd1 << digit_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in the block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      pend_full    <= 1'b0;
      active_valid <= 1'b0;
      wr_data      <= '0;
      digit_idx    <= 3'd0;
      overrun      <= 1'b0;
    end else begin
      if (upd_valid && upd_ready) pend_full <= 1'b1;
      if (scan_tick && busy)      overrun   <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (scan_tick) state <= ST_LOAD;
        end
        ST_LOAD: begin
          wr_data <= frame;
          state   <= ST_PULSE;
          if (use_pend) begin
            pend_full    <= 1'b0;
            active_valid <= 1'b1;
          end
        end
        ST_PULSE: begin
          wait_cnt <= CNT_W'(XFER_CYCLES - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state     <= ST_IDLE;
            digit_idx <= last_digit ? 3'd0 : digit_idx + 3'd1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the content buffers carry no reset; pend_full and active_valid
  // qualify them, so stale data is never observable.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_ready) begin
      pend_digits <= upd_digits;
      pend_dp     <= upd_dp;
      pend_aux    <= upd_aux;
    end
    if (state == ST_LOAD && use_pend) begin
      act_digits <= pend_digits;
      act_dp     <= pend_dp;
      act_aux    <= pend_aux;
    end
  end

endmodule
